// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues reads to a registered-output instruction memory and
// queues returning instructions in a credit-tracked FIFO. Optional perf counters under IFETCH_PERF_EN.
module instr_fetch #(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 30,
    parameter int RESET_PC = 0,
    parameter int DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               fetch_en,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetch_cnt,
    output logic [15:0]        perf_stall_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               inflight;
    logic               epoch;
    logic               tag_epoch;
    logic [PC_W-1:0]    tag_pc;

    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic [PC_W-1:0]    fifo_pc    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               pop;
    logic               push;
    logic               issue;
    logic [CNT_W:0]     credit_need;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // The memory writes whenever fetch_en is low, so it is never allowed to drop.
    assign fetch_en  = 1'b1;
    assign out_valid = (count != '0);
    assign out_instr = fifo_instr[rd_ptr];
    assign out_pc    = fifo_pc[rd_ptr];

    // Issue only if the response plus everything already owed still fits after this cycle's pop.
    always_comb begin
        pop         = out_valid && out_ready;
        push        = inflight && (tag_epoch == epoch) && !redirect_valid;
        credit_need = {1'b0, count} + (CNT_W + 1)'(inflight) + (CNT_W + 1)'(1)
                      - (CNT_W + 1)'(pop);
        issue       = !halt && !redirect_valid && (credit_need <= (CNT_W + 1)'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= PC_W'(RESET_PC);
            inflight  <= 1'b0;
            epoch     <= 1'b0;
            tag_epoch <= 1'b0;
            tag_pc    <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            epoch    <= ~epoch;
            inflight <= 1'b0;
        end else if (issue) begin
            pc        <= pc + PC_W'(1);
            inflight  <= 1'b1;
            tag_pc    <= pc;
            tag_epoch <= epoch;
        end else begin
            inflight <= 1'b0;
        end
    end

    // Redirect flushes the queue; a response landing in the same cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= instruction;
                fifo_pc[wr_ptr]    <= tag_pc;
                wr_ptr             <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && count == CNT_W'(DEPTH)));

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue && perf_fetch_cnt != 16'hFFFF) begin
                perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
            end
            if (out_valid && !out_ready && perf_stall_cnt != 16'hFFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch with a 1-cycle registered-read memory model.
// Perf counter checks run only when IFETCH_PERF_EN is defined.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en;
    logic [7:0]  pc;
    logic [29:0] instruction;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        halt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [29:0] out_instr;
    logic [7:0]  out_pc;
`ifdef IFETCH_PERF_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    typedef struct packed {
        logic [29:0] instr;
        logic [7:0]  pc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors_applied = 0;
    int   miscompares = 0;
    int   hs_cnt = 0;
    int   hs_start = 0;
    int   write_cnt = 0;
    logic [7:0] held_pc;

    instr_fetch dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_en(fetch_en),
        .pc(pc),
        .instruction(instruction),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt(halt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] mem_val(input logic [7:0] a);
        return {a ^ 8'h5A, 14'h1234, a};
    endfunction

    // Memory contents are fixed; a low fetch_en would be a write, so it is only counted.
    always @(posedge clk) begin
        if (fetch_en) begin
            instruction <= mem_val(pc);
        end else begin
            write_cnt <= write_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic pushBlock(input logic [7:0] start);
        logic [7:0] p;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            p = start + 8'(i);
            exp_q.push_back({mem_val(p), p});
        end
    endtask

    // Drives one cycle's inputs (applied at the next posedge) and scores any handshake.
    task automatic applyStimulus(input logic rst_in, input logic halt_in, input logic redir_in,
                                 input logic [7:0] target, input logic ready_in);
        exp_t e;
        rst_n          = rst_in;
        halt           = halt_in;
        redirect_valid = redir_in;
        redirect_pc    = target;
        out_ready      = ready_in;
        checkOutput("fetch_en", 64'(fetch_en), 64'd1);
        if (rst_in && out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_pc", 64'(out_pc), 64'(e.pc));
                checkOutput("out_instr", 64'(out_instr), 64'(e.instr));
                hs_cnt++;
            end
        end
        if (!rst_in) begin
            pushBlock(8'h00);
        end else if (redir_in) begin
            pushBlock(target);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state, then first-instruction latency and one-per-cycle throughput.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_pc", 64'(pc), 64'd0);
        checkOutput("rst_out_instr", 64'(out_instr), 64'd0);
        checkOutput("rst_out_pc", 64'(out_pc), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("lat_c1_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("lat_c2_valid", 64'(out_valid), 64'd1);
        checkOutput("lat_c2_pc", 64'(out_pc), 64'd0);
        hs_start = hs_cnt;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("rate_8", 64'(hs_cnt - hs_start), 64'd8);

        // Back-pressure from the first valid: head held, pc frozen once credits run out.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_head_pc", 64'(out_pc), 64'd0);
            checkOutput("stall_head_instr", 64'(out_instr), 64'(mem_val(8'h00)));
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        checkOutput("stall_pc_frozen", 64'(pc), 64'd2);
        hs_start = hs_cnt;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("release_rate", 64'(hs_cnt - hs_start), 64'd10);

        // Redirect with a full queue: flush, then target appears three cycles later.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("pre_redir_valid", 64'(out_valid), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h40, 1'b0);
        checkOutput("redir_r1_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("redir_r2_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("redir_r3_valid", 64'(out_valid), 64'd1);
        checkOutput("redir_r3_pc", 64'(out_pc), 64'h40);
        hs_start = hs_cnt;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("redir_count", 64'(hs_cnt - hs_start), 64'd4);

        // Redirect near the top of the address space to exercise wrap-around.
        hs_start = hs_cnt;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFE, 1'b1);
        hs_start = hs_cnt;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("wrap_count", 64'(hs_cnt - hs_start), 64'd6);

        // Halt: pc holds, queue drains, fetch resumes at the held pc.
        held_pc = pc;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
            checkOutput("halt_pc_hold", 64'(pc), 64'(held_pc));
        end
        checkOutput("halt_drained", 64'(out_valid), 64'd0);
        hs_start = hs_cnt;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("halt_resume", 64'(hs_cnt - hs_start), 64'd3);

        // Redirect while halted moves pc but issues nothing until halt drops.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h80, 1'b1);
        checkOutput("halt_redir_pc", 64'(pc), 64'h80);
        checkOutput("halt_redir_flush", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("halt_redir_hold", 64'(pc), 64'h80);
        checkOutput("halt_redir_idle", 64'(out_valid), 64'd0);
        hs_start = hs_cnt;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("halt_redir_resume", 64'(hs_cnt - hs_start), 64'd4);

        // Reset while streaming discards everything in flight.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_pc", 64'(pc), 64'd0);

`ifdef IFETCH_PERF_EN
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("perf_fetch", 64'(perf_fetch_cnt), 64'd10);
        checkOutput("perf_stall", 64'(perf_stall_cnt), 64'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("perf_fetch_rst", 64'(perf_fetch_cnt), 64'd0);
        checkOutput("perf_stall_rst", 64'(perf_stall_cnt), 64'd0);
        checkOutput("perf_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("perf_rst_pc", 64'(pc), 64'd0);
`endif

        hs_start = hs_cnt;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("post_rst_stream", 64'(hs_cnt - hs_start), 64'd2);
        checkOutput("mem_writes", 64'(write_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
